piso_lr: RTL and testbench

PISO_LR -- requirements
Module: piso_lr

---
 rtl/piso_lr.sv | 155 +++++++++++++++
 tb/tb_piso_lr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_lr.sv
// piso_lr -- parallel-in / serial-out shifter with selectable direction.
//
// Accepts a WIDTH-bit word through a valid/ready handshake and emits it one
// bit per clock on `so`, either MSB first (lr=0) or LSB first (lr=1).
// Back-to-back words stream without gaps when a new word is offered during
// the final bit cycle of the current frame.
//
// Optional build macro: PISO_PARITY_EN
//   When defined, every frame is followed by one extra cycle (state PAR)
//   carrying the even-parity bit of the captured word; that cycle becomes the
//   frame's last cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load_valid in   word on din is offered
//   load_ready out  word can be accepted this cycle
//   din        in   [WIDTH-1:0] parallel word
//   lr         in   direction, sampled at load (0 = MSB first, 1 = LSB first)
//   so         out  serial data
//   so_valid   out  so carries a valid bit
//   last       out  current bit is the final bit of the frame
module piso_lr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             lr,
  output logic             so,
  output logic             so_valid,
  output logic             last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t          state, state_next;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  logic load;      // handshake this edge: capture din/lr
  logic shift;     // advance register and counter
  logic bits_done; // current cycle carries the final data bit

  assign bits_done = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    so         = 1'b0;
    so_valid   = 1'b0;
    last       = 1'b0;
    load_ready = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        // State is forced to IDLE while rst_n is low; gate ready so nothing
        // is offered as accepted during reset.
        load_ready = rst_n;
        if (load_valid && rst_n) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        so       = dir ? sreg[0] : sreg[WIDTH-1];
        so_valid = 1'b1;
        if (bits_done) begin
`ifdef PISO_PARITY_EN
          state_next = PAR;
`else
          last       = 1'b1;
          load_ready = 1'b1;
          if (load_valid) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
`endif
        end else begin
          shift = 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        so         = par_q;
        so_valid   = 1'b1;
        last       = 1'b1;
        load_ready = 1'b1;
        if (load_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (load) begin
      sreg <= din;
      cnt  <= '0;
      dir  <= lr;
`ifdef PISO_PARITY_EN
      par_q <= ^din;
`endif
    end else if (shift) begin
      sreg <= dir ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
    end else if (state != IDLE && state_next == IDLE) begin
      // Frame ended with no follow-on word: leave no residue behind.
      sreg <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_lr.sv
// Directed self-checking bench for piso_lr at WIDTH=8 (works with or without
// PISO_PARITY_EN defined). Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_piso_lr;

`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 8 + PB;  // cycles per frame

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] din;
  logic       lr;
  logic       so;
  logic       so_valid;
  logic       last;

  int compared   = 0;
  int mismatched = 0;

  piso_lr #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .lr         (lr),
    .so         (so),
    .so_valid   (so_valid),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    compared++; if (so !== 1'b0) begin mismatched++; $display("FAIL rst so: got %b want 0", so); end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL rst so_valid: got %b want 0", so_valid); end
    compared++; if (last !== 1'b0) begin mismatched++; $display("FAIL rst last: got %b want 0", last); end
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL rst load_ready: got %b want 0", load_ready); end
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release load_ready: got %b want 1", load_ready); end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL rst_release so_valid: got %b want 0", so_valid); end
  endtask

  // One frame: exp_bits[7] is the first bit expected on so.
  task automatic test_frame(input string name, input logic [7:0] d, input logic l,
                            input logic [7:0] exp_bits, input logic exp_par);
    logic exp_so;
    logic exp_last;
    load_valid = 1'b1;
    din        = d;
    lr         = l;
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL %s idle load_ready: got %b want 1", name, load_ready); end
    tick;
    load_valid = 1'b0;
    din        = ~d;
    lr         = ~l;
    for (int i = 0; i < NB; i++) begin
      exp_so   = (i < 8) ? exp_bits[7-i] : exp_par;
      exp_last = (i == NB - 1);
      compared++; if (so !== exp_so) begin mismatched++; $display("FAIL %s bit%0d so: got %b want %b", name, i, so, exp_so); end
      compared++; if (so_valid !== 1'b1) begin mismatched++; $display("FAIL %s bit%0d so_valid: got %b want 1", name, i, so_valid); end
      compared++; if (last !== exp_last) begin mismatched++; $display("FAIL %s bit%0d last: got %b want %b", name, i, last, exp_last); end
      compared++; if (load_ready !== exp_last) begin mismatched++; $display("FAIL %s bit%0d load_ready: got %b want %b", name, i, load_ready, exp_last); end
      tick;
    end
    compared++; if (so !== 1'b0) begin mismatched++; $display("FAIL %s end so: got %b want 0", name, so); end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL %s end so_valid: got %b want 0", name, so_valid); end
    compared++; if (last !== 1'b0) begin mismatched++; $display("FAIL %s end last: got %b want 0", name, last); end
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL %s end load_ready: got %b want 1", name, load_ready); end
  endtask

  task automatic test_left;
    test_frame("left_A5", 8'hA5, 1'b0, 8'b1010_0101, 1'b0);
  endtask

  task automatic test_right;
    test_frame("right_A5", 8'hA5, 1'b1, 8'b1010_0101, 1'b0);
    test_frame("right_01", 8'h01, 1'b1, 8'b1000_0000, 1'b1);
  endtask

  // Without the parity macro these are plain left-shift frames.
  task automatic test_parity;
    test_frame("par_07", 8'h07, 1'b0, 8'b0000_0111, 1'b1);
    test_frame("par_03", 8'h03, 1'b0, 8'b0000_0011, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] fa;
    logic [7:0] fb;
    logic       e [0:2*NB-1];
    logic       exp_rdy;
    fa = 8'b1111_0000;  // F0, MSB first
    fb = 8'b1111_0000;  // 0F, LSB first
    for (int k = 0; k < NB; k++) begin
      e[k]      = (k < 8) ? fa[7-k] : 1'b0;
      e[NB + k] = (k < 8) ? fb[7-k] : 1'b0;
    end
    load_valid = 1'b1;
    din        = 8'hF0;
    lr         = 1'b0;
    tick;
    din = 8'h0F;
    lr  = 1'b1;
    for (int c = 0; c < 2 * NB; c++) begin
      if (c == 2 * NB - 1) load_valid = 1'b0;
      exp_rdy = (c == NB - 1) || (c == 2 * NB - 1);
      compared++; if (so !== e[c]) begin mismatched++; $display("FAIL b2b cyc%0d so: got %b want %b", c + 1, so, e[c]); end
      compared++; if (so_valid !== 1'b1) begin mismatched++; $display("FAIL b2b cyc%0d so_valid: got %b want 1", c + 1, so_valid); end
      compared++; if (load_ready !== exp_rdy) begin mismatched++; $display("FAIL b2b cyc%0d load_ready: got %b want %b", c + 1, load_ready, exp_rdy); end
      compared++; if (last !== exp_rdy) begin mismatched++; $display("FAIL b2b cyc%0d last: got %b want %b", c + 1, last, exp_rdy); end
      tick;
    end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL b2b end so_valid: got %b want 0", so_valid); end
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL b2b end load_ready: got %b want 1", load_ready); end
  endtask

  task automatic test_midframe_change;
    logic [7:0] exp_bits;
    logic       exp_so;
    logic       exp_rdy;
    exp_bits   = 8'b1010_0101;
    load_valid = 1'b1;
    din        = 8'hA5;
    lr         = 1'b0;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      din     = din + 8'h37;
      lr      = ~lr;
      #1;
      exp_so  = (i < 8) ? exp_bits[7-i] : 1'b0;
      exp_rdy = (i == NB - 1);
      compared++; if (so !== exp_so) begin mismatched++; $display("FAIL mid bit%0d so: got %b want %b", i, so, exp_so); end
      compared++; if (load_ready !== exp_rdy) begin mismatched++; $display("FAIL mid bit%0d load_ready: got %b want %b", i, load_ready, exp_rdy); end
      tick;
    end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL mid end so_valid: got %b want 0", so_valid); end
  endtask

  task automatic test_reset_midframe;
    load_valid = 1'b1;
    din        = 8'hFF;
    lr         = 1'b0;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared++; if (so !== 1'b1) begin mismatched++; $display("FAIL rstmid bit%0d so: got %b want 1", i, so); end
      if (i < 2) tick;
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (so !== 1'b0) begin mismatched++; $display("FAIL rstmid async so: got %b want 0", so); end
    compared++; if (so_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid async so_valid: got %b want 0", so_valid); end
    compared++; if (last !== 1'b0) begin mismatched++; $display("FAIL rstmid async last: got %b want 0", last); end
    compared++; if (load_ready !== 1'b0) begin mismatched++; $display("FAIL rstmid async load_ready: got %b want 0", load_ready); end
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    compared++; if (load_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid release load_ready: got %b want 1", load_ready); end
    for (int i = 0; i < 10; i++) begin
      tick;
      compared++; if (so_valid !== 1'b0 || so !== 1'b0) begin mismatched++; $display("FAIL rstmid residual cyc%0d so_valid/so: got %b/%b want 0/0", i, so_valid, so); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    din        = 8'h00;
    lr         = 1'b0;
    test_reset;
    test_left;
    test_right;
    test_parity;
    test_back_to_back;
    test_midframe_change;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
